// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the main-memory port: widths, size encoding, requester ids
// and the request record handed to the memory port.
package mem_port_arbiter_pkg;

    localparam int ADDR_WIDTH             = 32;
    localparam int WORD_WIDTH             = 32;
    localparam int ICACHE_DATA_BLOCK_SIZE = 64;

    // One-hot access size, {Word, Halfword, Byte}
    localparam logic [2:0] SIZE_BYTE = 3'b001;
    localparam logic [2:0] SIZE_HALF = 3'b010;
    localparam logic [2:0] SIZE_WORD = 3'b100;

    typedef enum logic [1:0] {
        PORT_IFU = 2'd0,
        PORT_LD  = 2'd1,
        PORT_ST  = 2'd2
    } port_id_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  wr;
        logic [2:0]            size;
        logic [WORD_WIDTH-1:0] wdata;
        port_id_e              port;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
// Purely combinational so it can be reused for issue select.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   grant_rot;
    logic [2*N-1:0] grant_dbl;

    // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
    assign req_dbl   = {req, req} >> ptr;
    assign req_rot   = req_dbl[N-1:0];
    assign grant_rot = req_rot & ~(req_rot - N'(1));
    assign grant_dbl = {grant_rot, grant_rot} << ptr;
    assign grant     = grant_dbl[2*N-1:N];

endmodule

// File: rtl/mem_port_arbiter.sv
// N-requester arbiter for the single main-memory port: round-robin grant into one
// registered request slot, in-order read-response routing, per-port read squash.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N_PORTS   = 3,
    parameter int ADDR_W    = ADDR_WIDTH,
    parameter int WORD_W    = WORD_WIDTH,
    parameter int BLOCK_W   = ICACHE_DATA_BLOCK_SIZE,
    parameter int MAX_OUTST = 4,
    localparam int PORT_W   = $clog2(N_PORTS),
    localparam int CNT_W    = $clog2(MAX_OUTST) + 1,
    localparam int PTR_W    = $clog2(MAX_OUTST)
) (
    input  logic                        clk,
    input  logic                        rst_aL,
    input  logic [N_PORTS-1:0]          req_valid,
    output logic [N_PORTS-1:0]          req_ready,
    input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [N_PORTS-1:0]          req_wr,
    input  logic [N_PORTS*3-1:0]        req_size,
    input  logic [N_PORTS*WORD_W-1:0]   req_wdata,
    input  logic [N_PORTS-1:0]          flush,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [ADDR_W-1:0]           mem_req_addr,
    output logic                        mem_req_wr,
    output logic [2:0]                  mem_req_size,
    output logic [WORD_W-1:0]           mem_req_wdata,
    output logic [PORT_W-1:0]           mem_req_port,
    input  logic                        mem_resp_valid,
    input  logic [BLOCK_W-1:0]          mem_resp_data,
    output logic [N_PORTS-1:0]          resp_valid,
    output logic [BLOCK_W-1:0]          resp_data,
    output logic [CNT_W-1:0]            outst_cnt,
    output logic                        resp_err
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [2:0]        size;
        logic [WORD_W-1:0] wdata;
        logic [PORT_W-1:0] port;
    } slot_t;

    logic                 slot_valid_reg;
    slot_t                slot_reg;
    logic [PORT_W-1:0]    rr_ptr_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [PORT_W-1:0]    fifo_port_reg [MAX_OUTST];
    logic [MAX_OUTST-1:0] fifo_squash_reg;

    logic [N_PORTS-1:0]   eligible;
    logic [N_PORTS-1:0]   arb_grant;
    logic [N_PORTS-1:0]   grant;
    logic                 slot_free;
    logic                 any_grant;
    logic                 cnt_full;
    logic                 push;
    logic                 pop;
    slot_t                grant_req;
    logic [PORT_W-1:0]    rr_ptr_next;
    logic [PORT_W-1:0]    head_port;
    logic                 head_squash;

    assign slot_free = !slot_valid_reg || mem_req_ready;
    assign cnt_full  = (cnt_reg >= CNT_W'(MAX_OUTST));

    // Reset gates the combinational outputs so nothing is offered while rst_aL is low.
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
        assign eligible[gi]   = rst_aL && req_valid[gi] && !flush[gi] && (req_wr[gi] || !cnt_full);
        assign resp_valid[gi] = rst_aL && pop && !head_squash && !flush[head_port]
                                && (head_port == PORT_W'(gi));
    end

    rr_arbiter #(
        .N     (N_PORTS),
        .PTR_W (PORT_W)
    ) u_rr_arbiter (
        .req   (eligible),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant)
    );

    assign grant     = slot_free ? arb_grant : '0;
    assign req_ready = grant;
    assign any_grant = |grant;

    always_comb begin
        grant_req = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant[i]) begin
                grant_req.addr  = req_addr[i*ADDR_W +: ADDR_W];
                grant_req.wr    = req_wr[i];
                grant_req.size  = req_size[i*3 +: 3];
                grant_req.wdata = req_wdata[i*WORD_W +: WORD_W];
                grant_req.port  = PORT_W'(i);
            end
        end
    end

    assign rr_ptr_next = (grant_req.port == PORT_W'(N_PORTS - 1)) ? '0
                                                                  : grant_req.port + PORT_W'(1);

    assign push        = any_grant && !grant_req.wr;
    assign pop         = mem_resp_valid && (cnt_reg != '0);
    assign head_port   = fifo_port_reg[rd_ptr_reg];
    assign head_squash = fifo_squash_reg[rd_ptr_reg];

    assign resp_err  = rst_aL && mem_resp_valid && (cnt_reg == '0);
    assign resp_data = mem_resp_data;
    assign outst_cnt = cnt_reg;

    assign mem_req_valid = slot_valid_reg;
    assign mem_req_addr  = slot_reg.addr;
    assign mem_req_wr    = slot_reg.wr;
    assign mem_req_size  = slot_reg.size;
    assign mem_req_wdata = slot_reg.wdata;
    assign mem_req_port  = slot_reg.port;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            slot_valid_reg <= 1'b0;
            slot_reg       <= '0;
            rr_ptr_reg     <= '0;
            cnt_reg        <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
        end else begin
            if (slot_free) begin
                slot_valid_reg <= any_grant;
                if (any_grant) begin
                    slot_reg <= grant_req;
                end
            end
            if (any_grant) begin
                rr_ptr_reg <= rr_ptr_next;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            cnt_reg <= cnt_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Flush marks every matching entry; a flush on the pushing port also squashes the new entry.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                fifo_port_reg[i] <= '0;
            end
            fifo_squash_reg <= '0;
        end else begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                if (push && (wr_ptr_reg == PTR_W'(i))) begin
                    fifo_port_reg[i]   <= grant_req.port;
                    fifo_squash_reg[i] <= flush[grant_req.port];
                end else if (flush[fifo_port_reg[i]]) begin
                    fifo_squash_reg[i] <= 1'b1;
                end
            end
        end
    end

endmodule
